syn_accum: RTL and testbench

Multi-beat, parametrised syndrome checker for the LDPC decoder. Each beat the decoder's routing network presents the gathered hard-decision bits of P check rows (DEG bits per row). The block XOR-reduces each row, compares the result against the reference syndrome bits supplied for QKD reconciliation, and accumulates the mismatches over N_CHECK/P beats. At end of frame it reports pass/fail and the unsatisfied-check count through a valid/ready handshake. It sits between the variable-node hard-decision stage and the decoder's iteration controller, which uses the result for early termination.

---
 rtl/syn_pkg.sv | 23 ++
 rtl/syn_popcnt.sv | 45 ++++
 rtl/syn_accum.sv | 145 ++++++++++++++
 tb/tb_syn_accum.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/syn_pkg.sv
// ============================================================================
// Module  : syn_pkg
// Brief   : Shared state type and width helper for the syndrome checker.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package syn_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } syn_state_t;

   // Bits needed to hold the values 0..n inclusive.
   function automatic int cw(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/syn_popcnt.sv
// ============================================================================
// Module  : syn_popcnt
// Brief   : Combinational population count built as a recursive adder tree.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module syn_popcnt
   import syn_pkg::*;
#(
   parameter int W = 64
) (
   input  logic [W-1:0]        in_i,
   output logic [cw(W)-1:0]    cnt_o
);

   localparam int OW = cw(W);

   generate
      if (W == 1) begin : g_leaf
         assign cnt_o = in_i;
      end else begin : g_split
         localparam int WL = W / 2;
         localparam int WH = W - WL;

         logic [cw(WL)-1:0] lo_cnt;
         logic [cw(WH)-1:0] hi_cnt;

         syn_popcnt #(.W(WL)) u_lo (
            .in_i  (in_i[WL-1:0]),
            .cnt_o (lo_cnt)
         );

         syn_popcnt #(.W(WH)) u_hi (
            .in_i  (in_i[W-1:WL]),
            .cnt_o (hi_cnt)
         );

         assign cnt_o = OW'(lo_cnt) + OW'(hi_cnt);
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/syn_accum.sv
// ============================================================================
// Module  : syn_accum
// Brief   : Multi-beat LDPC syndrome checker with valid/ready result port.
//           Define SYN_ERRCNT_EN to build the unsatisfied-check counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module syn_accum
   import syn_pkg::*;
#(
   parameter int P       = 64,
   parameter int DEG     = 10,
   parameter int N_CHECK = 512
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [P*DEG-1:0]          in_bits,
   input  logic [P-1:0]              in_target,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic                      syn_ok,
   output logic [cw(N_CHECK)-1:0]    err_cnt,
   output logic                      busy
);

   localparam int             BEATS     = N_CHECK / P;
   localparam int             CW        = cw(N_CHECK);
   localparam int             BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BW-1:0]  LAST_BEAT = BW'(BEATS - 1);

   syn_state_t       state_q, state_d;
   logic [BW-1:0]    beat_q;
   logic [P-1:0]     mis;
   logic             accept;
   logic             last_beat;
   logic             syn_ok_q;

   generate
      for (genvar r = 0; r < P; r++) begin : g_row
         assign mis[r] = (^in_bits[r*DEG +: DEG]) ^ in_target[r];
      end
   endgenerate

   assign accept    = in_valid && in_ready;
   assign last_beat = accept && (beat_q == LAST_BEAT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // start overrides every state, discarding any frame or pending result.
   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = ACCUM;
      end else begin
         case (state_q)
            IDLE:    state_d = IDLE;
            ACCUM:   if (last_beat) state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state_q == ACCUM);
      busy      = (state_q == ACCUM);
      res_valid = (state_q == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_q <= '0;
      end else if (start) begin
         beat_q <= '0;
      end else if (accept) begin
         beat_q <= last_beat ? '0 : beat_q + BW'(1);
      end
   end

`ifdef SYN_ERRCNT_EN
   logic [cw(P)-1:0] pop;
   logic [CW-1:0]    err_acc_q, err_acc_d;
   logic [CW-1:0]    err_cnt_q;

   syn_popcnt #(.W(P)) u_popcnt (
      .in_i  (mis),
      .cnt_o (pop)
   );

   assign err_acc_d = err_acc_q + CW'(pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_acc_q <= '0;
         err_cnt_q <= '0;
         syn_ok_q  <= 1'b0;
      end else if (start) begin
         err_acc_q <= '0;
      end else if (accept) begin
         err_acc_q <= err_acc_d;
         if (last_beat) begin
            err_cnt_q <= err_acc_d;
            syn_ok_q  <= (err_acc_d == '0);
         end
      end
   end

   assign err_cnt = err_cnt_q;
`else
   logic any_err_q, any_err_d;

   assign any_err_d = any_err_q | (|mis);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         any_err_q <= 1'b0;
         syn_ok_q  <= 1'b0;
      end else if (start) begin
         any_err_q <= 1'b0;
      end else if (accept) begin
         any_err_q <= any_err_d;
         if (last_beat) begin
            syn_ok_q <= ~any_err_d;
         end
      end
   end

   assign err_cnt = '0;
`endif

   assign syn_ok = syn_ok_q;

endmodule

`default_nettype wire

// File: tb/tb_syn_accum.sv
// ============================================================================
// Module  : tb_syn_accum
// Brief   : Directed/random self-checking bench for syn_accum.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_syn_accum;

   localparam int P       = 64;
   localparam int DEG     = 10;
   localparam int N_CHECK = 512;
   localparam int BEATS   = N_CHECK / P;
   localparam int CW      = $clog2(N_CHECK + 1);

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start;
   logic               in_valid;
   logic               in_ready;
   logic [P*DEG-1:0]   in_bits;
   logic [P-1:0]       in_target;
   logic               res_valid;
   logic               res_ready;
   logic               syn_ok;
   logic [CW-1:0]      err_cnt;
   logic               busy;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [P*DEG-1:0]   bits_a [BEATS];
   logic [P-1:0]       tgt_a  [BEATS];

   syn_accum #(.P(P), .DEG(DEG), .N_CHECK(N_CHECK)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bits   (in_bits),
      .in_target (in_target),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .syn_ok    (syn_ok),
      .err_cnt   (err_cnt),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [P*DEG-1:0] rand_bits();
      logic [P*DEG-1:0] v;
      for (int k = 0; k < P*DEG; k++) v[k] = 1'($urandom_range(0, 1));
      return v;
   endfunction

   function automatic logic [P-1:0] rand_tgt();
      logic [P-1:0] v;
      for (int k = 0; k < P; k++) v[k] = 1'($urandom_range(0, 1));
      return v;
   endfunction

   // Reference: a check fails when its row has odd weight but target 0, or vice versa.
   function automatic int ref_count();
      int n = 0;
      for (int b = 0; b < BEATS; b++) begin
         for (int r = 0; r < P; r++) begin
            int ones = 0;
            for (int d = 0; d < DEG; d++) ones += int'(bits_a[b][r*DEG + d]);
            if ((ones % 2) != int'(tgt_a[b][r])) n++;
         end
      end
      return n;
   endfunction

   function automatic logic [31:0] exp_err(input int n);
`ifdef SYN_ERRCNT_EN
      return 32'(n);
`else
      return 32'(n - n);
`endif
   endfunction

   task automatic clear_arrays();
      for (int b = 0; b < BEATS; b++) begin
         bits_a[b] = '0;
         tgt_a[b]  = '0;
      end
   endtask

   task automatic rand_arrays();
      for (int b = 0; b < BEATS; b++) begin
         bits_a[b] = rand_bits();
         tgt_a[b]  = rand_tgt();
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_in_ready", 32'(in_ready), 32'd1);
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_res_valid", 32'(res_valid), 32'd0);
   endtask

   task automatic drive_beats(input int nb, input bit gaps);
      int b = 0;
      int guard = 0;
      while (b < nb && guard < 100) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            in_bits  = rand_bits();
            in_target = rand_tgt();
         end else begin
            in_valid  = 1'b1;
            in_bits   = bits_a[b];
            in_target = tgt_a[b];
         end
         chk("in_ready_accum", 32'(in_ready), 32'd1);
         if (in_valid && in_ready) b++;
         step();
         guard++;
      end
      in_valid = 1'b0;
      if (b < nb) begin
         n_cmp++;
         n_fail++;
         $error("FAIL beat_timeout: observed=%0d expected=%0d", b, nb);
      end
   endtask

   task automatic check_result(input string tag);
      int n = ref_count();
      chk({tag, "_res_valid"}, 32'(res_valid), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_syn_ok"}, 32'(syn_ok), 32'(n == 0));
      chk({tag, "_err_cnt"}, 32'(err_cnt), exp_err(n));
   endtask

   // Holds res_ready low for 'hold' cycles while junk beats are offered, then consumes.
   task automatic release_result(input string tag, input int hold);
      int n = ref_count();
      for (int i = 0; i < hold; i++) begin
         in_valid  = 1'b1;
         in_bits   = rand_bits();
         in_target = rand_tgt();
         step();
         chk({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
         chk({tag, "_hold_ok"}, 32'(syn_ok), 32'(n == 0));
         chk({tag, "_hold_cnt"}, 32'(err_cnt), exp_err(n));
      end
      in_valid  = 1'b0;
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk({tag, "_idle_valid"}, 32'(res_valid), 32'd0);
      chk({tag, "_idle_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_idle_cnt"}, 32'(err_cnt), exp_err(n));
   endtask

   task automatic run_frame(input string tag, input bit gaps, input int hold);
      pulse_start();
      drive_beats(BEATS, gaps);
      check_result(tag);
      release_result(tag, hold);
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_bits   = '0;
      in_target = '0;
      res_ready = 1'b0;
      repeat (3) step();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_syn_ok", 32'(syn_ok), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      step();

      // Beats offered in IDLE must be ignored.
      in_valid = 1'b1;
      in_bits  = rand_bits();
      step();
      chk("idle_no_accept", 32'(in_ready), 32'd0);
      in_valid = 1'b0;

      clear_arrays();
      run_frame("zero", 1'b0, 0);

      clear_arrays();
      bits_a[3][17*DEG + 4] = 1'b1;
      run_frame("single", 1'b0, 0);
      tgt_a[3][17] = 1'b1;
      run_frame("single_tgt", 1'b0, 0);

      clear_arrays();
      for (int b = 0; b < BEATS; b++)
         for (int r = 0; r < P; r++) bits_a[b][r*DEG] = 1'b1;
      run_frame("all_odd", 1'b0, 0);

      rand_arrays();
      run_frame("rand_gaps", 1'b1, 5);
      rand_arrays();
      run_frame("rand_gaps2", 1'b1, 2);

      // Restart mid-frame: errored partial frame is discarded.
      rand_arrays();
      pulse_start();
      drive_beats(4, 1'b0);
      clear_arrays();
      pulse_start();
      drive_beats(BEATS, 1'b0);
      check_result("restart");

      // start together with res_ready goes straight back to ACCUM.
      start     = 1'b1;
      res_ready = 1'b1;
      step();
      start     = 1'b0;
      res_ready = 1'b0;
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
      chk("b2b_res_valid", 32'(res_valid), 32'd0);
      clear_arrays();
      bits_a[3][17*DEG + 4] = 1'b1;
      drive_beats(BEATS, 1'b0);
      check_result("b2b");
      release_result("b2b", 0);

      clear_arrays();
      run_frame("clean", 1'b0, 0);

      // Asynchronous reset mid-frame.
      pulse_start();
      drive_beats(3, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("arst_in_ready", 32'(in_ready), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_res_valid", 32'(res_valid), 32'd0);
      chk("arst_syn_ok", 32'(syn_ok), 32'd0);
      chk("arst_err_cnt", 32'(err_cnt), 32'd0);
      step();
      rst_n = 1'b1;
      step();

      rand_arrays();
      run_frame("post_rst", 1'b1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
